// File: rtl/button_debouncer_multi.sv
// N-channel push-button conditioner: synchroniser, bounce filter, press/release edges,
// long-press and auto-repeat pulses. Channels share nothing but the clock and reset.
module button_debouncer_multi #(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int HOLD_CYCLES     = 50_000_000,
  parameter int REPEAT_CYCLES   = 10_000_000,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o,
  output logic [N_CH-1:0] long_o,
  output logic [N_CH-1:0] repeat_o
);

  localparam int DW     = $clog2(DEBOUNCE_CYCLES);
  localparam int HR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW     = $clog2(HR_MAX + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_FULL = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] REP_LAST  = CW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
  localparam bit            REPEAT_EN = (REPEAT_CYCLES > 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HOLD   = 2'd1,
    ST_REPEAT = 2'd2
  } hold_state_e;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic          raw_s;
    logic          sync0_r;
    logic          sync1_r;
    logic          level_r;
    logic          level_next_s;
    logic          prev_r;
    logic [DW-1:0] db_cnt_r;
    logic          press_r;
    logic          release_r;
    logic          long_r;
    logic          repeat_r;
    logic [CW-1:0] hold_cnt_r;
    hold_state_e   state_r;

    assign raw_s = ACTIVE_LOW ? ~btn_in[ch] : btn_in[ch];

    // Two-flop synchroniser for the asynchronous button input
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync0_r <= 1'b0;
        sync1_r <= 1'b0;
      end else begin
        sync0_r <= raw_s;
        sync1_r <= sync0_r;
      end
    end

    // Level the filter will hold after the coming edge
    always_comb begin
      if ((sync1_r != level_r) && (db_cnt_r == DB_LAST)) begin
        level_next_s = sync1_r;
      end else begin
        level_next_s = level_r;
      end
    end

    // Stability window: any sample agreeing with the current level restarts it
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        level_r  <= 1'b0;
        db_cnt_r <= {DW{1'b0}};
      end else begin
        level_r <= level_next_s;
        if ((sync1_r == level_r) || (db_cnt_r == DB_LAST)) begin
          db_cnt_r <= {DW{1'b0}};
        end else begin
          db_cnt_r <= db_cnt_r + 1'b1;
        end
      end
    end

    // Press/release edge pulses from the debounced level
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        prev_r    <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
      end else begin
        prev_r    <= level_r;
        press_r   <= level_r & ~prev_r;
        release_r <= ~level_r & prev_r;
      end
    end

    // Hold FSM; keyed on the next level so a release accepted this edge cancels any pulse
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_r    <= ST_IDLE;
        hold_cnt_r <= {CW{1'b0}};
        long_r     <= 1'b0;
        repeat_r   <= 1'b0;
      end else if (!level_next_s) begin
        state_r    <= ST_IDLE;
        hold_cnt_r <= {CW{1'b0}};
        long_r     <= 1'b0;
        repeat_r   <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            repeat_r <= 1'b0;
            if (press_r && (HOLD_CYCLES == 1)) begin
              long_r     <= 1'b1;
              state_r    <= REPEAT_EN ? ST_REPEAT : ST_HOLD;
              hold_cnt_r <= REPEAT_EN ? {CW{1'b0}} : HOLD_FULL;
            end else if (press_r) begin
              long_r     <= 1'b0;
              state_r    <= ST_HOLD;
              hold_cnt_r <= CW'(1'b1);
            end else begin
              long_r <= 1'b0;
            end
          end
          ST_HOLD: begin
            repeat_r <= 1'b0;
            if (hold_cnt_r == HOLD_LAST) begin
              long_r     <= 1'b1;
              state_r    <= REPEAT_EN ? ST_REPEAT : ST_HOLD;
              hold_cnt_r <= REPEAT_EN ? {CW{1'b0}} : HOLD_FULL;
            end else if (hold_cnt_r < HOLD_FULL) begin
              long_r     <= 1'b0;
              hold_cnt_r <= hold_cnt_r + 1'b1;
            end else begin
              long_r <= 1'b0;
            end
          end
          ST_REPEAT: begin
            long_r <= 1'b0;
            if (hold_cnt_r == REP_LAST) begin
              repeat_r   <= 1'b1;
              hold_cnt_r <= {CW{1'b0}};
            end else begin
              repeat_r   <= 1'b0;
              hold_cnt_r <= hold_cnt_r + 1'b1;
            end
          end
          default: begin
            state_r    <= ST_IDLE;
            hold_cnt_r <= {CW{1'b0}};
            long_r     <= 1'b0;
            repeat_r   <= 1'b0;
          end
        endcase
      end
    end

    assign level_o[ch]   = level_r;
    assign press_o[ch]   = press_r;
    assign release_o[ch] = release_r;
    assign long_o[ch]    = long_r;
    assign repeat_o[ch]  = repeat_r;
  end

endmodule

// File: tb/tb_button_debouncer_multi.sv
// Bench for button_debouncer_multi: one active-high and one active-low instance checked
// every cycle against a sliding-window reference model, plus directed latency checks.
module tb_button_debouncer_multi;
  localparam int DB   = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;
  localparam logic [7:0] DMASK = 8'h0F;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [1:0] btn_a, btn_b;
  logic [1:0] lvl_a, press_a, rel_a, long_a, rep_a;
  logic [1:0] lvl_b, press_b, rel_b, long_b, rep_b;
  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;

  logic [7:0] hist [4];
  bit m_level [4];
  bit m_prev  [4];
  bit e_press [4];
  bit e_rel   [4];
  bit e_long  [4];
  bit e_rep   [4];
  bit armed   [4];
  int t_press [4];

  always #5 clk = ~clk;

  button_debouncer_multi #(.N_CH(2), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD),
                           .REPEAT_CYCLES(REP), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .reset_n(reset_n), .btn_in(btn_a), .level_o(lvl_a), .press_o(press_a),
    .release_o(rel_a), .long_o(long_a), .repeat_o(rep_a));

  button_debouncer_multi #(.N_CH(2), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD),
                           .REPEAT_CYCLES(REP), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .reset_n(reset_n), .btn_in(btn_b), .level_o(lvl_b), .press_o(press_b),
    .release_o(rel_b), .long_o(long_b), .repeat_o(rep_b));

  function automatic logic [19:0] act_vec();
    return {rep_b, long_b, rel_b, press_b, lvl_b, rep_a, long_a, rel_a, press_a, lvl_a};
  endfunction

  function automatic logic [19:0] exp_vec();
    logic [19:0] v;
    v = 20'h0;
    for (int m = 0; m < 4; m++) begin
      int b;
      b = (m / 2) * 10 + (m % 2);
      v[b]     = m_level[m];
      v[b + 2] = e_press[m];
      v[b + 4] = e_rel[m];
      v[b + 6] = e_long[m];
      v[b + 8] = e_rep[m];
    end
    return v;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 4; m++) begin
      hist[m] = 8'h00;
      m_level[m] = 1'b0; m_prev[m] = 1'b0;
      e_press[m] = 1'b0; e_rel[m] = 1'b0; e_long[m] = 1'b0; e_rep[m] = 1'b0;
      armed[m] = 1'b0; t_press[m] = 0;
    end
  endtask

  // A level flips once the last DB synchronised samples all disagree with it.
  task automatic model_step();
    logic p;
    logic [7:0] win;
    bit nl;
    int dt;
    for (int m = 0; m < 4; m++) begin
      p = (m < 2) ? btn_a[m % 2] : ~btn_b[m % 2];
      win = (hist[m] >> 1) & DMASK;
      nl = m_level[m];
      if (!m_level[m] && win == DMASK) nl = 1'b1;
      if (m_level[m] && win == 8'h00) nl = 1'b0;
      e_press[m] = m_level[m] & ~m_prev[m];
      e_rel[m]   = ~m_level[m] & m_prev[m];
      m_prev[m]  = m_level[m];
      m_level[m] = nl;
      hist[m] = {hist[m][6:0], p};
      if (e_press[m]) begin
        armed[m] = 1'b1;
        t_press[m] = edge_n;
      end
      if (!nl) armed[m] = 1'b0;
      dt = edge_n - t_press[m];
      e_long[m] = armed[m] && (dt == HOLD);
      e_rep[m]  = armed[m] && (dt > HOLD) && ((dt - HOLD) % REP == 0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    edge_n++;
    if (!reset_n) model_reset();
    else model_step();
    #1;
  endtask

  task automatic test_reset();
    btn_a = 2'b00;
    btn_b = 2'b11;
    reset_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (act_vec() !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_async: got %h expected %h", act_vec(), 20'h0);
    end
    repeat (3) begin
      step();
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_hold edge %0d: got %h expected %h", edge_n, act_vec(), exp_vec());
      end
    end
    reset_n = 1'b1;
    repeat (10) begin
      step();
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_idle edge %0d: got %h expected %h", edge_n, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_clean_press();
    int t0, tp;
    tp = -1;
    btn_a[0] = 1'b1;
    t0 = edge_n + 1;
    repeat (8) begin
      step();
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL clean_press edge %0d: got %h expected %h", edge_n, act_vec(), exp_vec());
      end
      if (press_a[0] && tp < 0) tp = edge_n;
    end
    vectors++;
    if (tp - t0 !== DB + 2) begin
      miscompares++;
      $display("FAIL clean_press_latency: got %0d expected %0d", tp - t0, DB + 2);
    end
    btn_a[0] = 1'b0;
    repeat (14) begin
      step();
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL clean_release edge %0d: got %h expected %h", edge_n, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_bounce();
    int tl, tp, np;
    tp = -1;
    np = 0;
    for (int k = 0; k < 4; k++) begin
      btn_a[0] = (k % 2 == 0);
      repeat (2) begin
        step();
        vectors++;
        if (act_vec() !== exp_vec()) begin
          miscompares++;
          $display("FAIL bounce edge %0d: got %h expected %h", edge_n, act_vec(), exp_vec());
        end
        if (press_a[0]) np++;
      end
    end
    btn_a[0] = 1'b1;
    tl = edge_n + 1;
    repeat (10) begin
      step();
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL bounce_settle edge %0d: got %h expected %h", edge_n, act_vec(), exp_vec());
      end
      if (press_a[0]) begin
        np++;
        if (tp < 0) tp = edge_n;
      end
    end
    vectors++;
    if (np !== 1 || tp - tl !== DB + 2) begin
      miscompares++;
      $display("FAIL bounce_press: got %0d presses at +%0d expected 1 at +%0d", np, tp - tl, DB + 2);
    end
    btn_a[0] = 1'b0;
    repeat (12) begin
      step();
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL bounce_release edge %0d: got %h expected %h", edge_n, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_long_repeat();
    int tp, tl, nrep, nrel;
    int rep_e [3];
    tp = -1; tl = -1; nrep = 0; nrel = 0;
    rep_e[0] = -1; rep_e[1] = -1; rep_e[2] = -1;
    btn_a[1] = 1'b1;
    repeat (60) begin
      step();
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL long_repeat edge %0d: got %h expected %h", edge_n, act_vec(), exp_vec());
      end
      if (press_a[1] && tp < 0) tp = edge_n;
      if (long_a[1]) tl = edge_n;
      if (rep_a[1]) begin
        if (nrep < 3) rep_e[nrep] = edge_n;
        nrep++;
      end
      if (rel_a[1]) nrel++;
      if (tp >= 0 && edge_n == tp + 16) btn_a[1] = 1'b0;
    end
    vectors++;
    if (tl - tp !== HOLD || nrep !== 3 || nrel !== 1) begin
      miscompares++;
      $display("FAIL long_summary: got long +%0d, %0d repeats, %0d releases expected +%0d, 3, 1",
               tl - tp, nrep, nrel, HOLD);
    end
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (rep_e[k] - tp !== HOLD + REP * (k + 1)) begin
        miscompares++;
        $display("FAIL repeat_time[%0d]: got +%0d expected +%0d", k, rep_e[k] - tp, HOLD + REP * (k + 1));
      end
    end
  endtask

  task automatic test_short_press();
    int tp, tr, nlong;
    bit dropped;
    tp = -1; tr = -1; nlong = 0; dropped = 1'b0;
    btn_a[0] = 1'b1;
    repeat (30) begin
      step();
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL short_press edge %0d: got %h expected %h", edge_n, act_vec(), exp_vec());
      end
      if (press_a[0] && tp < 0) tp = edge_n;
      if (rel_a[0] && tr < 0) tr = edge_n;
      if (long_a[0]) nlong++;
      if (lvl_a[0] && !dropped) begin
        btn_a[0] = 1'b0;
        dropped = 1'b1;
      end
    end
    vectors++;
    if (tr - tp !== 6 || nlong !== 0) begin
      miscompares++;
      $display("FAIL short_press_result: got release +%0d, %0d long expected +6, 0", tr - tp, nlong);
    end
  endtask

  task automatic test_active_low();
    int t0, tp, np;
    tp = -1; np = 0;
    btn_b[0] = 1'b0;
    t0 = edge_n + 1;
    repeat (20) begin
      step();
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL active_low edge %0d: got %h expected %h", edge_n, act_vec(), exp_vec());
      end
      if (press_b[0]) begin
        np++;
        if (tp < 0) tp = edge_n;
      end
    end
    vectors++;
    if (np !== 1 || tp - t0 !== DB + 2) begin
      miscompares++;
      $display("FAIL active_low_press: got %0d at +%0d expected 1 at +%0d", np, tp - t0, DB + 2);
    end
    btn_b[0] = 1'b1;
    repeat (15) begin
      step();
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL active_low_release edge %0d: got %h expected %h", edge_n, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    int tp, t0, tp2;
    bit hit;
    tp = -1; tp2 = -1; hit = 1'b0;
    btn_a[1] = 1'b1;
    for (int k = 0; k < 30 && !hit; k++) begin
      step();
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_mid_pre edge %0d: got %h expected %h", edge_n, act_vec(), exp_vec());
      end
      if (press_a[1] && tp < 0) tp = edge_n;
      if (tp >= 0 && edge_n == tp + 7) hit = 1'b1;
    end
    vectors++;
    if (!hit) begin
      miscompares++;
      $display("FAIL reset_mid_timeout: got no press within 30 cycles expected one");
    end
    reset_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (act_vec() !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_mid_drop: got %h expected %h", act_vec(), 20'h0);
    end
    repeat (2) step();
    reset_n = 1'b1;
    t0 = edge_n + 1;
    repeat (12) begin
      step();
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset_mid_post edge %0d: got %h expected %h", edge_n, act_vec(), exp_vec());
      end
      if (press_a[1] && tp2 < 0) tp2 = edge_n;
    end
    vectors++;
    if (tp2 - t0 !== DB + 2) begin
      miscompares++;
      $display("FAIL reset_mid_repress: got +%0d expected +%0d", tp2 - t0, DB + 2);
    end
    btn_a[1] = 1'b0;
    repeat (12) step();
  endtask

  task automatic test_random();
    int left [4];
    for (int m = 0; m < 4; m++) left[m] = $urandom_range(1, 40);
    repeat (900) begin
      for (int m = 0; m < 4; m++) begin
        if (left[m] == 0) begin
          if (m < 2) btn_a[m] = ~btn_a[m];
          else btn_b[m - 2] = ~btn_b[m - 2];
          left[m] = $urandom_range(1, 40);
        end else begin
          left[m]--;
        end
      end
      step();
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random edge %0d: got %h expected %h", edge_n, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_repeat();
    test_short_press();
    test_active_low();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
